// File: rtl/codificador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codificador_pkg
// Description : Shared constants, state encoding and the select-to-one-hot
//               helper for the 16:1 event encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package codificador_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    GAP_WAIT = 2'd2
  } state_t;

  // The same 4-to-16 decode the demux uses, reused here to clear the
  // pending bit of the accepted channel.
  function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [N_CH-1:0] dec;
    dec      = '0;
    dec[sel] = 1'b1;
    return dec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/modulo_rr_arbitro16.sv
`default_nettype none
// ============================================================================
// Module      : modulo_rr_arbitro16
// Description : Combinational 16-way arbiter. Round-robin from last+1 with
//               wrap, or fixed lowest-index priority when prio_low is set.
// Ports       : req      - request mask
//               last     - channel granted most recently
//               prio_low - 1 selects fixed priority, lowest index wins
//               idx      - winning channel
//               found    - any request present
// Revision    : 1.0 - initial release
// ============================================================================
module modulo_rr_arbitro16
  import codificador_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  input  logic             prio_low,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [N_CH-1:0] hi_mask;
  logic [N_CH-1:0] upper;
  logic [N_CH-1:0] search;

  always_comb begin
    // Channels strictly after the last winner get first look; if none of
    // them requests, the search wraps to the full mask, whose lowest set bit
    // is then the first one at or after channel 0.
    for (int i = 0; i < N_CH; i++) begin
      hi_mask[i] = (SEL_W'(i) > last);
    end
    upper  = req & hi_mask;
    search = (prio_low || (upper == '0)) ? req : upper;

    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (search[i]) begin
        idx = SEL_W'(i);
      end
    end
  end

  assign found = |req;

endmodule
`default_nettype wire

// File: rtl/modulo_codificador16_1.sv
`default_nettype none
// ============================================================================
// Module      : modulo_codificador16_1
// Description : 16:1 event encoder. Rising edges on D become pending events;
//               pending events are serialized as a 4-bit code S with a
//               valid strobe E and a valid/ack handshake.
// Parameters  : GAP      - idle clocks after each accept (0..15)
//               PRIO_LOW - 0 round-robin, 1 fixed lowest-index priority
// Ports       : clk, rst_n (async, active-low)
//               D        - request lines, rising edge = one event
//               ACK      - consumer accepts S when ACK and E are both high
//               OVF_CLR  - synchronous clear of OVF
//               S, E     - grant code and grant valid
//               PEND     - registered pending-event mask
//               OVF      - sticky lost-event flag
// Revision    : 1.0 - initial release
// ============================================================================
module modulo_codificador16_1
  import codificador_pkg::*;
#(
  parameter int GAP      = 0,
  parameter bit PRIO_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  D,
  input  logic             ACK,
  input  logic             OVF_CLR,
  output logic [SEL_W-1:0] S,
  output logic             E,
  output logic [N_CH-1:0]  PEND,
  output logic             OVF
);

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t           state, state_nxt;
  logic [N_CH-1:0]  d_q;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  clr;
  logic             accept;
  logic             ovf_evt;
  logic [SEL_W-1:0] last, last_nxt;
  logic [SEL_W-1:0] s_nxt;
  logic             e_nxt;
  logic [3:0]       gap_cnt, gap_nxt;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_found;

  modulo_rr_arbitro16 u_arbitro (
    .req      (PEND),
    .last     (last),
    .prio_low (PRIO_LOW),
    .idx      (arb_idx),
    .found    (arb_found)
  );

  // E is only high in GRANT, so ACK outside a grant has no effect.
  assign accept  = E && ACK;
  assign rise    = D & ~d_q;
  assign clr     = accept ? onehot(S) : '0;
  // A rise on a channel being cleared on the same edge is a fresh event,
  // not a lost one.
  assign ovf_evt = |(rise & PEND & ~clr);

  always_comb begin
    state_nxt = state;
    s_nxt     = S;
    e_nxt     = E;
    last_nxt  = last;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: begin
        e_nxt = 1'b0;
        if (arb_found) begin
          s_nxt     = arb_idx;
          e_nxt     = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // S is frozen until accepted; no re-arbitration here.
        if (ACK) begin
          last_nxt = S;
          e_nxt    = 1'b0;
          gap_nxt  = '0;
          if (GAP > 0) begin
            state_nxt = GAP_WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP_WAIT: begin
        e_nxt   = 1'b0;
        gap_nxt = gap_cnt + 4'd1;
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        e_nxt     = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      S       <= '0;
      E       <= 1'b0;
      last    <= 4'd15;
      gap_cnt <= '0;
      d_q     <= '0;
      PEND    <= '0;
      OVF     <= 1'b0;
    end else begin
      state   <= state_nxt;
      S       <= s_nxt;
      E       <= e_nxt;
      last    <= last_nxt;
      gap_cnt <= gap_nxt;
      d_q     <= D;
      PEND    <= (PEND & ~clr) | rise;
      if (ovf_evt) begin
        OVF <= 1'b1;
      end else if (OVF_CLR) begin
        OVF <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_modulo_codificador16_1.sv
`default_nettype none
// ============================================================================
// Module      : tb_modulo_codificador16_1
// Description : Self-checking bench for modulo_codificador16_1. Two
//               instances: GAP=0 and GAP=3, both round-robin. Expected grant
//               codes are queued by the stimulus and popped by a monitor on
//               each new grant; timing, PEND and OVF are checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modulo_codificador16_1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] d0, d3;
  logic        ack0, ack3, clr0, clr3;
  logic [3:0]  s0, s3;
  logic        e0, e3, ovf0, ovf3;
  logic [15:0] pend0, pend3;

  int checks   = 0;
  int failures = 0;
  logic [3:0] q0[$];
  logic [3:0] q3[$];

  always #5 clk = ~clk;

  modulo_codificador16_1 #(.GAP(0), .PRIO_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .D(d0), .ACK(ack0), .OVF_CLR(clr0),
    .S(s0), .E(e0), .PEND(pend0), .OVF(ovf0)
  );

  modulo_codificador16_1 #(.GAP(3), .PRIO_LOW(1'b0)) dut3 (
    .clk(clk), .rst_n(rst_n), .D(d3), .ACK(ack3), .OVF_CLR(clr3),
    .S(s3), .E(e3), .PEND(pend3), .OVF(ovf3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    d0 = '0; d3 = '0; ack0 = 1'b0; ack3 = 1'b0; clr0 = 1'b0; clr3 = 1'b0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitors: one pop per new grant (rising E).
  initial begin : mon0
    logic ep;
    ep = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ep = 1'b0;
      end else begin
        if (e0 && !ep) begin
          if (q0.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon0_grant: got unexpected grant S=%0d expected no grant", s0);
          end else begin
            chk("mon0_grant_S", {28'h0, s0}, {28'h0, q0.pop_front()});
          end
        end
        ep = e0;
      end
    end
  end

  initial begin : mon3
    logic ep;
    ep = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ep = 1'b0;
      end else begin
        if (e3 && !ep) begin
          if (q3.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon3_grant: got unexpected grant S=%0d expected no grant", s3);
          end else begin
            chk("mon3_grant_S", {28'h0, s3}, {28'h0, q3.pop_front()});
          end
        end
        ep = e3;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] t2s [4];
    int n;
    t2s = '{4'd0, 4'd5, 4'd10, 4'd15};

    // ---- reset state
    d0 = '0; d3 = '0; ack0 = 1'b0; ack3 = 1'b0; clr0 = 1'b0; clr3 = 1'b0;
    rst_n = 1'b0;
    tick;
    chk("rst_S",    {28'h0, s0}, 32'h0);
    chk("rst_E",    {31'h0, e0}, 32'h0);
    chk("rst_PEND", {16'h0, pend0}, 32'h0);
    chk("rst_OVF",  {31'h0, ovf0}, 32'h0);
    chk("rst_E3",   {31'h0, e3}, 32'h0);

    // ---- test 1: single channel held high
    do_reset;
    q0.push_back(4'd0);
    d0 = 16'h0001; ack0 = 1'b1;
    tick;
    chk("t1_pend_after_rise", {16'h0, pend0}, 32'h0001);
    chk("t1_e_before_grant",  {31'h0, e0}, 32'h0);
    tick;
    chk("t1_e_grant", {31'h0, e0}, 32'h1);
    chk("t1_s_grant", {28'h0, s0}, 32'h0);
    tick;
    chk("t1_e_after_accept", {31'h0, e0}, 32'h0);
    chk("t1_pend_cleared",   {16'h0, pend0}, 32'h0);
    repeat (4) tick;
    chk("t1_no_regrant", {31'h0, e0}, 32'h0);
    chk("t1_pend_idle",  {16'h0, pend0}, 32'h0);

    // ---- test 2: four simultaneous rises, round-robin order
    do_reset;
    foreach (t2s[i]) q0.push_back(t2s[i]);
    d0 = 16'h8421; ack0 = 1'b1;
    tick;
    chk("t2_pend_all", {16'h0, pend0}, 32'h8421);
    for (int j = 0; j < 8; j++) begin
      tick;
      chk($sformatf("t2_e_%0d", j), {31'h0, e0}, ((j % 2) == 0) ? 32'h1 : 32'h0);
      if ((j % 2) == 0) begin
        chk($sformatf("t2_s_%0d", j), {28'h0, s0}, {28'h0, t2s[j/2]});
      end
    end
    chk("t2_pend_end", {16'h0, pend0}, 32'h0);

    // ---- test 3: grant held while another channel rises
    do_reset;
    q0.push_back(4'd3);
    q0.push_back(4'd1);
    d0 = 16'h0008; ack0 = 1'b0;
    tick;
    tick;
    chk("t3_e_grant", {31'h0, e0}, 32'h1);
    chk("t3_s_grant", {28'h0, s0}, 32'h3);
    d0 = 16'h000A;
    for (int j = 0; j < 5; j++) begin
      tick;
      chk($sformatf("t3_s_hold_%0d", j), {28'h0, s0}, 32'h3);
      chk($sformatf("t3_e_hold_%0d", j), {31'h0, e0}, 32'h1);
    end
    chk("t3_pend_both", {16'h0, pend0}, 32'h000A);
    ack0 = 1'b1;
    tick;
    chk("t3_e_after_accept", {31'h0, e0}, 32'h0);
    chk("t3_pend_after",     {16'h0, pend0}, 32'h0002);
    ack0 = 1'b0;
    tick;
    chk("t3_e_second", {31'h0, e0}, 32'h1);
    chk("t3_s_second", {28'h0, s0}, 32'h1);
    ack0 = 1'b1;
    tick;
    ack0 = 1'b0;
    chk("t3_pend_end", {16'h0, pend0}, 32'h0);

    // ---- test 4: overflow while grant waits, OVF_CLR
    do_reset;
    q0.push_back(4'd7);
    d0 = 16'h0080;
    tick;
    d0 = 16'h0000;
    tick;
    chk("t4_e_grant", {31'h0, e0}, 32'h1);
    chk("t4_s_grant", {28'h0, s0}, 32'h7);
    chk("t4_ovf_pre", {31'h0, ovf0}, 32'h0);
    d0 = 16'h0080;
    tick;
    chk("t4_ovf_set", {31'h0, ovf0}, 32'h1);
    d0 = 16'h0000;
    tick;
    d0 = 16'h0080;
    tick;
    d0 = 16'h0000;
    tick;
    chk("t4_s_held", {28'h0, s0}, 32'h7);
    ack0 = 1'b1;
    tick;
    ack0 = 1'b0;
    chk("t4_e_after_accept", {31'h0, e0}, 32'h0);
    chk("t4_pend_cleared",   {16'h0, pend0}, 32'h0);
    repeat (3) tick;
    chk("t4_no_regrant", {31'h0, e0}, 32'h0);
    chk("t4_ovf_sticky", {31'h0, ovf0}, 32'h1);
    clr0 = 1'b1;
    tick;
    clr0 = 1'b0;
    chk("t4_ovf_cleared", {31'h0, ovf0}, 32'h0);

    // ---- test 5: re-rise on the accept edge
    do_reset;
    q0.push_back(4'd2);
    q0.push_back(4'd2);
    d0 = 16'h0004;
    tick;
    tick;
    chk("t5_s_grant", {28'h0, s0}, 32'h2);
    d0 = 16'h0000;
    tick;
    d0 = 16'h0004; ack0 = 1'b1;
    tick;
    chk("t5_pend_kept", {16'h0, pend0}, 32'h0004);
    chk("t5_ovf_zero",  {31'h0, ovf0}, 32'h0);
    chk("t5_e_gap",     {31'h0, e0}, 32'h0);
    tick;
    chk("t5_e_second", {31'h0, e0}, 32'h1);
    chk("t5_s_second", {28'h0, s0}, 32'h2);
    tick;
    chk("t5_pend_end", {16'h0, pend0}, 32'h0);
    ack0 = 1'b0; d0 = 16'h0000;

    // ---- test 6: GAP=3 spacing, then async reset mid-grant
    do_reset;
    q3.push_back(4'd0);
    q3.push_back(4'd1);
    d3 = 16'h0003; ack3 = 1'b1;
    tick;
    tick;
    chk("t6_e_first", {31'h0, e3}, 32'h1);
    chk("t6_s_first", {28'h0, s3}, 32'h0);
    tick;
    chk("t6_e_after_accept", {31'h0, e3}, 32'h0);
    n = 0;
    while (e3 == 1'b0 && n < 20) begin
      n++;
      tick;
    end
    ack3 = 1'b0;
    chk("t6_gap_low_cycles", n, 32'd4);
    chk("t6_s_second", {28'h0, s3}, 32'h1);
    d3 = 16'h0010;
    tick;
    d3 = 16'h0000;
    tick;
    d3 = 16'h0010;
    tick;
    chk("t6_e_held",   {31'h0, e3}, 32'h1);
    chk("t6_ovf_set",  {31'h0, ovf3}, 32'h1);
    chk("t6_pend_set", {16'h0, pend3}, 32'h0012);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_E",    {31'h0, e3}, 32'h0);
    chk("t6_async_PEND", {16'h0, pend3}, 32'h0);
    chk("t6_async_OVF",  {31'h0, ovf3}, 32'h0);
    chk("t6_async_S",    {28'h0, s3}, 32'h0);
    d3 = 16'h0000;
    tick;
    rst_n = 1'b1;
    tick;

    chk("q0_drained", q0.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
